// File: rtl/pmc_pkg.sv
// Shared constants and types for the programmable performance-monitor controller.
package pmc_pkg;

    localparam int NEV  = 8;   // raw event strobes
    localparam int NCNT = 4;   // general-purpose counters
    localparam int SELW = 3;   // event select field width

    // Window state machine
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } pmc_state_e;

    // Register offsets (full 32-bit compare)
    localparam logic [31:0] OFF_CTRL   = 32'h00;
    localparam logic [31:0] OFF_SEL    = 32'h04;
    localparam logic [31:0] OFF_STATUS = 32'h08;
    localparam logic [31:0] OFF_MASK   = 32'h0C;
    localparam logic [31:0] OFF_CNT0   = 32'h10;
    localparam logic [31:0] OFF_SNAP0  = 32'h20;
    localparam logic [31:0] OFF_WINDOW = 32'h30;

    // CTRL bit positions
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_CLR_BIT  = 1;
    localparam int CTRL_SNAP_BIT = 2;

    // STATUS bit positions: ovf[i] at bit i, done above them
    localparam int STAT_OVF_LSB = 0;
    localparam int STAT_DONE_BIT = 4;
    localparam int STATW = 5;

    // Offset of counter / snapshot register i
    function automatic logic [31:0] cnt_off(input int i);
        return OFF_CNT0 + 32'(4 * i);
    endfunction

    function automatic logic [31:0] snap_off(input int i);
        return OFF_SNAP0 + 32'(4 * i);
    endfunction

endpackage

// File: rtl/mod_pmc_ctrl_slice.sv
// One counter lane: event select, 32-bit counter, overflow detect, snapshot.
module pmc_counter_slice
    import pmc_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [NEV-1:0]  events,
    input  logic [SELW-1:0] sel,
    input  logic            run,
    input  logic            clr,
    input  logic            load,
    input  logic [31:0]     load_data,
    input  logic            snap,
    input  logic            win_end,
    output logic [31:0]     cnt,
    output logic [31:0]     snap_val,
    output logic            ovf_set
);

    logic        ev;
    logic [31:0] cnt_next;

    assign ev = events[sel];

    // Counter next value: clear beats bus load beats increment
    always_comb begin
        cnt_next = cnt;
        if (clr) begin
            cnt_next = '0;
        end else if (load) begin
            cnt_next = load_data;
        end else if (run && ev) begin
            cnt_next = cnt + 32'd1;
        end
    end

    // Only a genuine increment through all-ones counts as an overflow
    assign ovf_set = run && ev && !clr && !load && (cnt == 32'hFFFF_FFFF);

    // Counter and snapshot registers; window-end captures the post-update count
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            snap_val <= '0;
        end else begin
            cnt <= cnt_next;
            if (win_end) begin
                snap_val <= cnt_next;
            end else if (snap) begin
                snap_val <= cnt;
            end
        end
    end

endmodule

// File: rtl/mod_pmc_ctrl.sv
// Performance-monitor controller: bus decode, window FSM, status/mask/irq.
module mod_pmc_ctrl
    import pmc_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           ie,
    input  logic           de,
    input  logic [31:0]    iaddr,
    input  logic [31:0]    daddr,
    input  logic [1:0]     drw,
    input  logic [31:0]    din,
    output logic [31:0]    iout,
    output logic [31:0]    dout,
    input  logic [NEV-1:0] events,
    output logic           irq
);

    // Handshake: there is no back-pressure. A write is taken on any clk
    // negedge where de && drw[0]; reads are combinational on daddr.

    pmc_state_e             state_q, state_d;
    logic                   en_q;
    logic [NCNT*SELW-1:0]   sel_q;
    logic [STATW-1:0]       status_q;
    logic [STATW-1:0]       mask_q;
    logic [31:0]            window_q;
    logic [31:0]            remaining_q;

    logic                   wr, ctrl_wr, run, win_end, clr, snap;
    logic [NCNT-1:0]        cnt_wr;
    logic [NCNT-1:0]        ovf_set;
    logic [31:0]            cnt      [NCNT];
    logic [31:0]            snap_val [NCNT];
    logic                   unused_bits;

    assign unused_bits = ^{ie, iaddr, drw[1]};
    assign iout        = '0;

    assign wr      = de && drw[0];
    assign ctrl_wr = wr && (daddr == OFF_CTRL);
    assign clr     = ctrl_wr && din[CTRL_CLR_BIT];
    assign snap    = ctrl_wr && din[CTRL_SNAP_BIT];
    assign run     = (state_q == ST_RUN);

    // A CTRL write in the last window cycle takes over the state decision
    assign win_end = run && !ctrl_wr && (window_q != 32'd0) && (remaining_q == 32'd1);

    genvar g;
    generate
        for (g = 0; g < NCNT; g++) begin : g_slice
            assign cnt_wr[g] = wr && (daddr == cnt_off(g));
            pmc_counter_slice u_slice (
                .clk       (clk),
                .rst       (rst),
                .events    (events),
                .sel       (sel_q[SELW*g +: SELW]),
                .run       (run),
                .clr       (clr),
                .load      (cnt_wr[g]),
                .load_data (din),
                .snap      (snap),
                .win_end   (win_end),
                .cnt       (cnt[g]),
                .snap_val  (snap_val[g]),
                .ovf_set   (ovf_set[g])
            );
        end
    endgenerate

    // Window FSM next state: CTRL writes steer, otherwise the window may expire
    always_comb begin
        state_d = state_q;
        if (ctrl_wr) begin
            state_d = din[CTRL_EN_BIT] ? ST_RUN : ST_IDLE;
        end else if (win_end) begin
            state_d = ST_DONE;
        end
    end

    // Control/config registers, window down-counter and sticky status flags
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            en_q        <= 1'b0;
            sel_q       <= '0;
            status_q    <= '0;
            mask_q      <= '0;
            window_q    <= '0;
            remaining_q <= '0;
        end else begin
            state_q <= state_d;
            if (ctrl_wr) en_q <= din[CTRL_EN_BIT];
            if (wr && daddr == OFF_SEL)    sel_q    <= din[NCNT*SELW-1:0];
            if (wr && daddr == OFF_MASK)   mask_q   <= din[STATW-1:0];
            if (wr && daddr == OFF_WINDOW) window_q <= din;
            if (ctrl_wr && din[CTRL_EN_BIT]) begin
                remaining_q <= window_q;
            end else if (run) begin
                remaining_q <= remaining_q - 32'd1;
            end
            // Set wins over write-1-to-clear in the same cycle
            status_q <= (status_q & ~((wr && daddr == OFF_STATUS) ? din[STATW-1:0] : '0))
                      | {win_end, ovf_set};
        end
    end

    assign irq = |(status_q & mask_q);

    // Read mux; unmapped offsets return zero
    always_comb begin
        dout = '0;
        case (daddr)
            OFF_CTRL:   dout = {26'd0, state_q, 3'd0, en_q};
            OFF_SEL:    dout = {20'd0, sel_q};
            OFF_STATUS: dout = {27'd0, status_q};
            OFF_MASK:   dout = {27'd0, mask_q};
            OFF_WINDOW: dout = window_q;
            default:    dout = '0;
        endcase
        for (int i = 0; i < NCNT; i++) begin
            if (daddr == cnt_off(i))  dout = cnt[i];
            if (daddr == snap_off(i)) dout = snap_val[i];
        end
    end

endmodule

// File: tb/tb_mod_pmc_ctrl.sv
// Directed scoreboard bench for mod_pmc_ctrl.
module tb_mod_pmc_ctrl;

    localparam logic [31:0] A_CTRL   = 32'h00;
    localparam logic [31:0] A_SEL    = 32'h04;
    localparam logic [31:0] A_STATUS = 32'h08;
    localparam logic [31:0] A_MASK   = 32'h0C;
    localparam logic [31:0] A_CNT0   = 32'h10;
    localparam logic [31:0] A_CNT1   = 32'h14;
    localparam logic [31:0] A_CNT2   = 32'h18;
    localparam logic [31:0] A_CNT3   = 32'h1C;
    localparam logic [31:0] A_SNAP0  = 32'h20;
    localparam logic [31:0] A_SNAP1  = 32'h24;
    localparam logic [31:0] A_WINDOW = 32'h30;

    // clock / reset
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    always #5 clk = ~clk;

    logic        ie = 1'b0;
    logic        de = 1'b0;
    logic [31:0] iaddr = '0;
    logic [31:0] daddr = '0;
    logic [1:0]  drw = '0;
    logic [31:0] din = '0;
    logic [31:0] iout;
    logic [31:0] dout;
    logic [7:0]  events = '0;
    logic        irq;

    mod_pmc_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .ie     (ie),
        .de     (de),
        .iaddr  (iaddr),
        .daddr  (daddr),
        .drw    (drw),
        .din    (din),
        .iout   (iout),
        .dout   (dout),
        .events (events),
        .irq    (irq)
    );

    // scoreboard state
    logic [31:0] exp_q[$];
    logic        kind_q[$];      // 0: dout, 1: irq
    string       name_q[$];
    logic        chk_valid = 1'b0;
    logic        done_flag = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;

    // driver: one bus/event cycle, launched just after a negedge
    task automatic drive(input logic d, input logic w, input logic [31:0] a,
                         input logic [31:0] data, input logic [7:0] ev,
                         input logic ck, input logic kind,
                         input logic [31:0] exp, input string nm);
        @(negedge clk);
        #1;
        de        = d;
        drw       = {1'b0, w};
        daddr     = a;
        din       = data;
        events    = ev;
        chk_valid = ck;
        if (ck) begin
            exp_q.push_back(exp);
            kind_q.push_back(kind);
            name_q.push_back(nm);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] data, input logic [7:0] ev);
        drive(1'b1, 1'b1, a, data, ev, 1'b0, 1'b0, 32'd0, "");
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
        drive(1'b1, 1'b0, a, 32'd0, 8'd0, 1'b1, 1'b0, exp, nm);
    endtask

    task automatic cyc(input logic [7:0] ev);
        drive(1'b0, 1'b0, 32'd0, 32'd0, ev, 1'b0, 1'b0, 32'd0, "");
    endtask

    task automatic chk_irq(input logic exp, input string nm);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 8'd0, 1'b1, 1'b1, {31'd0, exp}, nm);
    endtask

    // monitor: compare on posedge, away from the negedge update
    always @(posedge clk) begin
        logic [31:0] e;
        logic [31:0] act;
        logic        k;
        string       nm;
        if (chk_valid) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_check: no expected entry queued");
            end else begin
                e   = exp_q.pop_front();
                k   = kind_q.pop_front();
                nm  = name_q.pop_front();
                act = k ? {31'd0, irq} : dout;
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, e);
                end
            end
        end else if (done_flag) begin
            n_tests++;
            if (exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL leftover_checks: got %0d pending expected 0", exp_q.size());
            end
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // stimulus
    initial begin
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b1;

        // reset values across the whole map
        for (int i = 0; i <= 12; i++) begin
            rd(32'(4 * i), 32'd0, "reset_read");
        end
        chk_irq(1'b0, "reset_irq");

        // free-run counting of event 3 into CNT0, then hold in IDLE
        wr(A_SEL, 32'h3, 8'h00);
        wr(A_CTRL, 32'h1, 8'h00);
        repeat (5) begin
            cyc(8'h08);
            cyc(8'h00);
        end
        rd(A_CTRL, 32'h11, "ctrl_run");
        wr(A_CTRL, 32'h0, 8'h00);
        cyc(8'h08);
        cyc(8'h08);
        rd(A_CNT0, 32'd5, "cnt0_freerun");
        rd(A_CTRL, 32'h0, "ctrl_idle");

        // 10-cycle window with event 0 held high
        wr(A_WINDOW, 32'd10, 8'h00);
        rd(A_WINDOW, 32'd10, "window_rb");
        wr(A_CTRL, 32'h1, 8'h01);
        repeat (12) cyc(8'h01);
        rd(A_CNT1, 32'd10, "cnt1_window");
        rd(A_SNAP1, 32'd10, "snap1_window");
        rd(A_SNAP0, 32'd5, "snap0_window");
        rd(A_CTRL, 32'h21, "ctrl_done");
        rd(A_STATUS, 32'h10, "status_done");
        chk_irq(1'b0, "irq_unmasked");
        wr(A_MASK, 32'h10, 8'h00);
        chk_irq(1'b1, "irq_done");
        wr(A_STATUS, 32'h10, 8'h00);
        chk_irq(1'b0, "irq_w1c");
        rd(A_STATUS, 32'h0, "status_w1c");

        // CNT2 wrap on event 5, and set-over-clear collision
        wr(A_CTRL, 32'h0, 8'h00);
        wr(A_WINDOW, 32'd0, 8'h00);
        wr(A_SEL, 32'hD43, 8'h00);
        wr(A_CNT2, 32'hFFFF_FFFE, 8'h00);
        wr(A_CTRL, 32'h1, 8'h00);
        repeat (3) cyc(8'h20);
        rd(A_CNT2, 32'd1, "cnt2_wrap");
        rd(A_STATUS, 32'h04, "ovf2_set");
        wr(A_STATUS, 32'h04, 8'h00);
        rd(A_STATUS, 32'h00, "ovf2_w1c");
        wr(A_CNT2, 32'hFFFF_FFFF, 8'h00);
        wr(A_STATUS, 32'h04, 8'h20);
        rd(A_STATUS, 32'h04, "ovf2_set_wins");
        rd(A_CNT2, 32'd0, "cnt2_wrap2");
        chk_irq(1'b0, "irq_ovf_masked");

        // load beats increment; clr beats increment and leaves flags/snap
        wr(A_CNT3, 32'h100, 8'h40);
        rd(A_CNT3, 32'h100, "cnt3_load_wins");
        wr(A_CTRL, 32'h3, 8'h40);
        rd(A_CNT3, 32'd0, "cnt3_clr_wins");
        rd(A_CNT2, 32'd0, "cnt2_clr");
        rd(A_STATUS, 32'h04, "status_after_clr");
        rd(A_CTRL, 32'h11, "ctrl_after_clr");
        rd(A_SNAP1, 32'd10, "snap1_after_clr");

        // snap pulse captures pre-update count while counting continues
        repeat (7) cyc(8'h08);
        wr(A_CTRL, 32'h5, 8'h08);
        cyc(8'h08);
        rd(A_SNAP0, 32'd7, "snap0_pulse");
        rd(A_CNT0, 32'd9, "cnt0_after_snap");

        // asynchronous reset mid-RUN
        wr(A_MASK, 32'h1F, 8'h00);
        chk_irq(1'b1, "irq_ovf_unmasked");
        rd(A_CTRL, 32'h0, "rst_async_state");
        rst = 1'b0;
        rd(A_CNT0, 32'd0, "rst_cnt0");
        chk_irq(1'b0, "rst_irq");
        cyc(8'h00);
        rst = 1'b1;
        rd(A_CNT2, 32'd0, "rst_cnt2");
        rd(A_STATUS, 32'd0, "rst_status");
        rd(A_SNAP0, 32'd0, "rst_snap0");
        rd(A_SEL, 32'd0, "rst_sel");

        cyc(8'h00);
        done_flag = 1'b1;
    end

endmodule
